// File: rtl/uart_pkg.sv
// uart_pkg: shared parity constants, TX state type and configuration helpers
// for the buffered UART transmitter.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} tx_state_e;

    function automatic int baud_div(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic bit cfg_legal(input int clock_freq, input int baud_rate, input int data_bits,
                                     input int parity, input int stop_bits, input int fifo_depth);
        return baud_div(clock_freq, baud_rate) >= 2 && data_bits >= 5 && data_bits <= 9 &&
               parity >= PARITY_NONE && parity <= PARITY_EVEN && stop_bits >= 1 && stop_bits <= 2 &&
               fifo_depth >= 2 && (fifo_depth & (fifo_depth - 1)) == 0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two FIFO with a level counter; read data follows the
// read pointer so the head word is valid in the same cycle it is popped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             full, push_ok, pop_ok;

    // The extra pointer bit separates full from empty when the addresses match.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = wr_ptr_q == rd_ptr_q;
    assign push_ok = push_i && !full;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign level_o = level_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: buffered UART transmitter with parameterised data width, parity
// and stop bits; queued frames go out back-to-back with no idle gap.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [DATA_BITS-1:0]        s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int BAUD_DIV = baud_div(CLOCK_FREQ, BAUD_RATE);
    localparam int BW       = $clog2(BAUD_DIV);
    localparam int CW       = $clog2(DATA_BITS);
    localparam int LW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
    localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);

    if (!cfg_legal(CLOCK_FREQ, BAUD_RATE, DATA_BITS, PARITY, STOP_BITS, FIFO_DEPTH)) begin : g_bad_cfg
        $error("uart_tx_cfg: illegal parameter combination");
    end

    tx_state_e            state_q;
    logic [BW-1:0]        baud_q;
    logic [CW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q, rdata;
    logic                 parity_q, tx_q, empty, pop, baud_end, stop_end;

    assign baud_end = baud_q == BAUD_LAST;
    assign stop_end = state_q == S_STOP && baud_end && bit_q == STOP_LAST;
    // Popping on the last stop cycle lets the next start bit begin on the following edge.
    assign pop      = !empty && (state_q == S_IDLE || stop_end);
    assign s_ready  = fifo_level < DEPTH_L;
    assign busy     = state_q != S_IDLE || fifo_level != '0;
    assign tx       = tx_q;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (s_valid && s_ready),
        .pop_i   (pop),
        .wdata_i (s_data),
        .rdata_o (rdata),
        .level_o (fifo_level),
        .empty_o (empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            baud_q <= (state_q == S_IDLE || baud_end) ? '0 : baud_q + 1'b1;
            if (pop) begin
                state_q  <= S_START;
                shift_q  <= rdata;
                parity_q <= ^rdata ^ (PARITY == PARITY_ODD);
                bit_q    <= '0;
                tx_q     <= 1'b0;
            end else if (baud_end) begin
                case (state_q)
                    S_START: begin
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                    S_DATA: begin
                        if (bit_q == DATA_LAST) begin
                            state_q <= PARITY != PARITY_NONE ? S_PARITY : S_STOP;
                            tx_q    <= PARITY != PARITY_NONE ? parity_q : 1'b1;
                            bit_q   <= '0;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                    S_PARITY: begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end
                    S_STOP: begin
                        if (bit_q == STOP_LAST) state_q <= S_IDLE;
                        else bit_q <= bit_q + 1'b1;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: three configurations (8N1, 8E1, 7O2) driven side by side and
// checked every cycle against a frame-level reference model.
module tb_uart_tx_cfg;
    localparam int N = 3;
    localparam int CF [N] = '{700, 700, 500};
    localparam int BR [N] = '{100, 100, 100};
    localparam int DB [N] = '{8, 8, 7};
    localparam int PR [N] = '{0, 2, 1};
    localparam int SB [N] = '{1, 1, 2};
    localparam int DP [N] = '{16, 4, 2};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [8:0] sd = '0;
    logic [N-1:0] sv = '0, tx, busy, rdy;
    logic [4:0] lvl [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [$clog2(DP[g]):0] l;
        uart_tx_cfg #(.CLOCK_FREQ(CF[g]), .BAUD_RATE(BR[g]), .DATA_BITS(DB[g]), .PARITY(PR[g]),
                      .STOP_BITS(SB[g]), .FIFO_DEPTH(DP[g])) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .s_data     (sd[DB[g]-1:0]),
            .s_valid    (sv[g]),
            .s_ready    (rdy[g]),
            .tx         (tx[g]),
            .busy       (busy[g]),
            .fifo_level (l)
        );
        assign lvl[g] = 5'(l);
    end

    // Reference model: queued words, plus the frame on the line and its start cycle.
    logic [8:0]  mem [N][256];
    logic [15:0] fb [N];
    int wr [N], rd [N], st [N];
    bit act [N];
    int cyc = 0;
    int tests = 0, fails = 0;

    function automatic int bd(input int k);
        return CF[k] / BR[k];
    endfunction

    function automatic int nbits(input int k);
        return 1 + DB[k] + (PR[k] != 0 ? 1 : 0) + SB[k];
    endfunction

    function automatic logic [15:0] frame(input int k, input logic [8:0] w);
        logic [15:0] f = '1;
        int ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < DB[k]; i++) begin
            f[1+i] = w[i];
            ones += int'(w[i]);
        end
        if (PR[k] != 0) f[1+DB[k]] = (PR[k] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
        return f;
    endfunction

    function automatic bit model_idle();
        bit r = 1'b1;
        for (int k = 0; k < N; k++) if (act[k] || wr[k] != rd[k]) r = 1'b0;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            wr[k] = 0; rd[k] = 0; st[k] = 0; act[k] = 1'b0; fb[k] = '1;
        end
    endtask

    task automatic model_edge();
        cyc++;
        for (int k = 0; k < N; k++) begin
            int lv = wr[k] - rd[k];
            bit done = act[k] && (cyc - st[k] == nbits(k) * bd(k));
            bit push = sv[k] && lv < DP[k];
            if ((!act[k] || done) && lv > 0) begin
                fb[k] = frame(k, mem[k][rd[k] % 256]);
                st[k] = cyc;
                act[k] = 1'b1;
                rd[k]++;
            end else if (done) act[k] = 1'b0;
            if (push) begin
                mem[k][wr[k] % 256] = sd & 9'((1 << DB[k]) - 1);
                wr[k]++;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < N; k++) begin
            int lv = wr[k] - rd[k];
            logic [7:0] e = {act[k] ? fb[k][(cyc - st[k]) / bd(k)] : 1'b1, act[k] || lv != 0, lv < DP[k], 5'(lv)};
            logic [7:0] a = {tx[k], busy[k], rdy[k], lvl[k]};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL model dut%0d cyc %0d: tx/busy/rdy/lvl got %b want %b", k, cyc, a, e);
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        model_edge();
        check_all();
    endtask

    task automatic wait_idle();
        int g = 0;
        while (!model_idle() && g < 3000) begin
            step();
            g++;
        end
        tests++;
        if (!model_idle()) begin
            fails++;
            $display("FAIL wait_idle: got busy after %0d cycles want idle", g);
        end
    endtask

    typedef struct {
        int          k;
        logic [8:0]  w;
        logic [15:0] bits;
        int          n;
    } vec_t;
    vec_t vt [5];

    int k, b, n, drop, g;
    bit acc;

    initial begin
        vt[0] = '{0, 9'h055, 16'h02AA, 10};
        vt[1] = '{1, 9'h007, 16'h060E, 11};
        vt[2] = '{1, 9'h000, 16'h0400, 11};
        vt[3] = '{2, 9'h041, 16'h0782, 11};
        vt[4] = '{2, 9'h07F, 16'h06FE, 11};
        model_reset();
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("reset_tx%0d", i), tx[i], 1);
            chk($sformatf("reset_busy%0d", i), busy[i], 0);
            chk($sformatf("reset_rdy%0d", i), rdy[i], 1);
            chk($sformatf("reset_lvl%0d", i), lvl[i], 0);
        end
        reset_n = 1'b1;

        // Directed single frames: hand-computed line patterns and busy fall time.
        for (int v = 0; v < 5; v++) begin
            k = vt[v].k;
            b = bd(k);
            wait_idle();
            sd = vt[v].w;
            sv[k] = 1'b1;
            step();
            sv = '0;
            for (int c = 1; c <= vt[v].n * b + 1; c++) begin
                step();
                if (c <= vt[v].n * b && (c - 1) % b == b / 2)
                    chk($sformatf("vec%0d_bit%0d", v, (c - 1) / b), tx[k], vt[v].bits[(c - 1) / b]);
                if (c == vt[v].n * b) chk($sformatf("vec%0d_busy_end", v), busy[k], 1);
                if (c == vt[v].n * b + 1) chk($sformatf("vec%0d_busy_fall", v), busy[k], 0);
            end
        end

        // s_valid held high on the 16-deep FIFO for 20 words.
        wait_idle();
        n = 0; drop = -1; g = 0;
        while (n < 20 && g < 5000) begin
            sd = 9'($urandom);
            sv[0] = 1'b1;
            acc = rdy[0];
            step();
            g++;
            if (acc) n++;
            if (drop < 0 && !rdy[0]) drop = n;
        end
        sv = '0;
        chk("fill_first_drop", drop, 17);
        chk("fill_all_accepted", n, 20);
        wait_idle();

        // Push and pop on the same edge at level 1; the pushed word is the next frame.
        sd = 9'h000;
        sv[1] = 1'b1;
        step();
        sd = 9'h001;
        step();
        sv = '0;
        chk("pushpop_level", lvl[1], 1);
        repeat (nbits(1) * bd(1) + bd(1) + bd(1) / 2) step();
        chk("pushpop_d0", tx[1], 1);
        repeat (bd(1)) step();
        chk("pushpop_d1", tx[1], 0);
        wait_idle();

        // Asynchronous reset during data bit 3 of dut0 with words still queued.
        sd = 9'h15A;
        sv = '1;
        repeat (3) step();
        sv = '0;
        repeat (4 * bd(0) + 2) step();
        chk("pre_reset_lvl0", lvl[0], 2);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("async_tx%0d", i), tx[i], 1);
            chk($sformatf("async_busy%0d", i), busy[i], 0);
            chk($sformatf("async_rdy%0d", i), rdy[i], 1);
            chk($sformatf("async_lvl%0d", i), lvl[i], 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        check_all();
        sd = 9'h0A3;
        sv = '1;
        step();
        sv = '0;
        wait_idle();

        // Randomised traffic on all three configurations.
        for (int i = 0; i < 2500; i++) begin
            sd = 9'($urandom);
            sv = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
            step();
        end
        sv = '0;
        wait_idle();
        for (int i = 0; i < N; i++) chk($sformatf("final_busy%0d", i), busy[i], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Configurable, buffered UART transmitter. It is the next-generation serial TX for the USB-UART debug/telemetry path. Data width, parity mode and stop-bit count are set by parameters. An internal FIFO accepts words over a valid/ready handshake, and queued frames are sent back-to-back with no idle gap. It sits between on-chip producers (register dumps, frame statistics) and the USB-UART bridge pin.

## Interface
Parameters:
- CLOCK_FREQ, 50000000, clk frequency in Hz
- BAUD_RATE, 115200, line rate in bit/s; BAUD_DIV = CLOCK_FREQ / BAUD_RATE (integer truncation, must be ≥ 2)
- DATA_BITS, 8, data bits per frame, legal range 5..9
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even
- STOP_BITS, 1, stop bits per frame, 1 or 2
- FIFO_DEPTH, 16, buffer depth; must be a power of 2 and ≥ 2

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- s_data  in  DATA_BITS  word to transmit
- s_valid  in  1  s_data is valid
- s_ready  out  1  FIFO can accept a word; a word is accepted when s_valid && s_ready at a rising edge
- tx  out  1  serial line, registered, idles high
- busy  out  1  a frame is in progress or the FIFO is non-empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of words currently queued

## Operation
- Frame format:
  - start bit 0
  - DATA_BITS data bits, LSB first
  - optional parity bit
  - STOP_BITS stop bits, value 1
- Each bit lasts exactly BAUD_DIV clk cycles.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × BAUD_DIV cycles.
- Parity:
  - odd: the bit makes the count of ones over data plus parity odd.
  - even: the bit makes that count even.
  - Parity is computed from the word when it is loaded into the shift register.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop one word, load the shift register, set tx=0 and go to START.
  - START → DATA after BAUD_DIV cycles.
  - DATA: shift out one bit per BAUD_DIV cycles. After bit DATA_BITS-1, go to PARITY if PARITY≠0, otherwise to STOP.
  - PARITY → STOP after BAUD_DIV cycles.
  - STOP lasts STOP_BITS × BAUD_DIV cycles. On its last cycle:
    - FIFO non-empty: pop the next word and go directly to START, so tx falls on the following edge.
    - FIFO empty: go to IDLE.
- The bit counter and baud counter are sized with $clog2 of their maximum values. The baud counter wraps from BAUD_DIV-1 to 0.
- s_ready = (fifo_level < FIFO_DEPTH), combinational from the level register.
- busy = (state ≠ IDLE) || (fifo_level ≠ 0).
- Simultaneous push and pop: the level is unchanged and data order is preserved.
- A full FIFO with a simultaneous pop still shows s_ready=0 in that cycle, so no write is accepted.

## Timing
- Reset values: tx=1, busy=0, s_ready=1, fifo_level=0, state IDLE, FIFO pointers 0.
- Assertion of reset takes effect immediately (asynchronous). Reset mid-frame aborts the frame, drives tx high and discards all queued words.
- Latency, with the FSM idle and the FIFO empty:
  - The word is accepted at edge E0, and fifo_level=1 after E0.
  - The FSM pops at E1, and tx=0 from E1.
  - The start bit spans E1 to E1+BAUD_DIV.
- Back-to-back frames: the tx high time between consecutive frames is exactly STOP_BITS × BAUD_DIV cycles.
- fifo_level updates on the same edge as the handshake or pop.
- Changes on s_data or s_valid while s_ready=0 have no effect.

## Structure
- Package uart_pkg holds:
  - parity constants PARITY_NONE, PARITY_ODD, PARITY_EVEN
  - the FSM state typedef
  - a baud_div(CLOCK_FREQ, BAUD_RATE) function
  - parameter-legality checks
- Sub-module sync_fifo (parameters WIDTH, DEPTH) holds:
  - the storage array and wrap-around pointers with one extra bit for full/empty
  - the level counter
  - a registered-address read, with the output valid in the same cycle as pop
- uart_tx_cfg contains the FSM, baud counter, shift register and parity generation.

## Test plan
All scenarios use CLOCK_FREQ=50e6 and BAUD_RATE=115200, so BAUD_DIV=434.
- 8N1, push 0x55 → tx is 0, 1,0,1,0,1,0,1,0, 1, each bit 434 cycles; frame is 4340 cycles; busy falls 4341 cycles after acceptance.
- 8E1, push 0x07 → parity bit 1, frame 4774 cycles. 8O1, push 0x07 → parity bit 0.
- DATA_BITS=7, STOP_BITS=2, push 0x41 → bits 1,0,0,0,0,0,1 after the start bit; tx high for 868 cycles before IDLE.
- FIFO_DEPTH=16, s_valid held high with 20 words → 17 accepted before s_ready first drops (one is popped at E1); all 20 are sent in order; gaps between frames are exactly 434 cycles.
- Level 1, concurrent push and pop → fifo_level stays 1, and the next frame carries the pushed word.
- reset_n low during data bit 3 → tx=1, busy=0, fifo_level=0, s_ready=1 asynchronously; after release, 0xA3 transmits as a clean frame.
